// File: rtl/mem_pkg.sv
// Shared load/store definitions: size encodings, exception codes, FSM states, lane masks.
package mem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RESP
    } lsuState_e;

    // Byte-lane mask for an access of the given size, lane 0 aligned.
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        logic [7:0] mask;
        case (size)
            SZ_B:    mask = 8'h01;
            SZ_H:    mask = 8'h03;
            SZ_W:    mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_load_extract.sv
// Pulls the addressed byte/half/word/dword out of an SRAM line and sign/zero-extends it.
module load_extract
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0]             rdata,
    input  logic [$clog2(DATA_W/8)-1:0]   off,
    input  logic [1:0]                    size,
    input  logic                          isUnsigned,
    output logic [DATA_W-1:0]             result
);

    logic [DATA_W-1:0] shifted;

    // Lane-align the addressed data, then truncate and extend to the access size.
    always_comb begin
        shifted = rdata >> {off, 3'b000};
        result  = shifted;
        case (size)
            SZ_B: begin
                if (isUnsigned) result = DATA_W'(shifted[7:0]);
                else            result = DATA_W'($signed(shifted[7:0]));
            end
            SZ_H: begin
                if (isUnsigned) result = DATA_W'(shifted[15:0]);
                else            result = DATA_W'($signed(shifted[15:0]));
            end
            SZ_W: begin
                if (isUnsigned) result = DATA_W'(shifted[31:0]);
                else            result = DATA_W'($signed(shifted[31:0]));
            end
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store unit: drives the data SRAM port, sequences fixed-latency reads,
// flags misaligned accesses. One request in flight at a time.
module lsu_mem_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [1:0]             req_size,
    input  logic                   req_unsigned,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [DATA_W-1:0]      req_wdata,
    output logic                   data_sram_en,
    output logic [DATA_W/8-1:0]    data_sram_wen,
    output logic [ADDR_W-1:0]      data_sram_addr,
    output logic [DATA_W-1:0]      data_sram_wdata,
    input  logic [DATA_W-1:0]      data_sram_rdata,
    output logic                   resp_valid,
    output logic [DATA_W-1:0]      resp_rdata,
    output logic                   resp_exc,
    output logic [4:0]             resp_exc_code,
    output logic [ADDR_W-1:0]      resp_badvaddr
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);
    localparam int unsigned CNT_W  = 2;

    lsuState_e         state;
    logic [CNT_W-1:0]  cnt;
    logic [OFF_W-1:0]  offQ;
    logic [1:0]        sizeQ;
    logic              unsQ;
    logic              respValidQ;
    logic [DATA_W-1:0] respRdataQ;
    logic              respExcQ;
    logic [4:0]        respCodeQ;
    logic [ADDR_W-1:0] respBadQ;

    logic              accept;
    logic              misaligned;
    logic              sramAccess;
    logic [OFF_W-1:0]  off;
    logic [DATA_W-1:0] extracted;

    // Request decode: lane offset, alignment check, handshake.
    always_comb begin
        off       = req_addr[OFF_W-1:0];
        req_ready = (state == IDLE) && !reset;
        accept    = req_valid && req_ready && !flush;
        case (req_size)
            SZ_B:    misaligned = 1'b0;
            SZ_H:    misaligned = req_addr[0];
            SZ_W:    misaligned = (req_addr[1:0] != 2'b00);
            default: misaligned = (DATA_W == 32) || (req_addr[2:0] != 3'b000);
        endcase
        sramAccess = accept && !misaligned;
    end

    // SRAM strobe is live only in the accept cycle; stores shift mask and data into lane.
    always_comb begin
        data_sram_en    = sramAccess;
        data_sram_wen   = '0;
        data_sram_addr  = '0;
        data_sram_wdata = '0;
        if (sramAccess) begin
            data_sram_addr = {req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
            if (req_we) begin
                data_sram_wen   = STRB_W'({8'h00, size_mask(req_size)} << off);
                data_sram_wdata = req_wdata << {off, 3'b000};
            end
        end
    end

    load_extract #(
        .DATA_W(DATA_W)
    ) u_load_extract (
        .rdata      (data_sram_rdata),
        .off        (offQ),
        .size       (sizeQ),
        .isUnsigned (unsQ),
        .result     (extracted)
    );

    // Request FSM; response registers are one-cycle pulses loaded on entry to RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            offQ       <= '0;
            sizeQ      <= SZ_B;
            unsQ       <= 1'b0;
            respValidQ <= 1'b0;
            respRdataQ <= '0;
            respExcQ   <= 1'b0;
            respCodeQ  <= '0;
            respBadQ   <= '0;
        end else begin
            respValidQ <= 1'b0;
            respRdataQ <= '0;
            respExcQ   <= 1'b0;
            respCodeQ  <= '0;
            respBadQ   <= '0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (misaligned) begin
                            state      <= RESP;
                            respValidQ <= 1'b1;
                            respExcQ   <= 1'b1;
                            respCodeQ  <= req_we ? EXC_ADES : EXC_ADEL;
                            respBadQ   <= req_addr;
                        end else if (req_we) begin
                            state      <= RESP;
                            respValidQ <= 1'b1;
                        end else begin
                            state <= RD_WAIT;
                            cnt   <= CNT_W'(RD_LAT - 1);
                            offQ  <= off;
                            sizeQ <= req_size;
                            unsQ  <= req_unsigned;
                        end
                    end
                end
                RD_WAIT: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        state      <= RESP;
                        respValidQ <= 1'b1;
                        respRdataQ <= extracted;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // A flush during the response cycle cancels the response.
    always_comb begin
        resp_valid    = respValidQ && !flush;
        resp_rdata    = flush ? '0 : respRdataQ;
        resp_exc      = respExcQ && !flush;
        resp_exc_code = flush ? '0 : respCodeQ;
        resp_badvaddr = flush ? '0 : respBadQ;
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: A = 32b/RD_LAT1, B = 32b/RD_LAT3, C = 64b/RD_LAT1.
module tb_lsu_mem_ctrl;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        reqValid = 1'b0;
    logic        reqWe = 1'b0;
    logic [1:0]  reqSize = SZ_B;
    logic        reqUns = 1'b0;
    logic [31:0] reqAddr = '0;
    logic [63:0] reqWdata = '0;
    logic [31:0] rdataA = '0;
    logic [31:0] rdataB = '0;
    logic [63:0] rdataC = '0;

    logic        readyA, enA, rvA, excA;
    logic [3:0]  wenA;
    logic [31:0] addrA, wdataA, respA, badA;
    logic [4:0]  codeA;
    logic        readyB, enB, rvB, excB;
    logic [3:0]  wenB;
    logic [31:0] addrB, wdataB, respB, badB;
    logic [4:0]  codeB;
    logic        readyC, enC, rvC, excC;
    logic [7:0]  wenC;
    logic [31:0] addrC, badC;
    logic [63:0] wdataC, respC;
    logic [4:0]  codeC;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.DATA_W(32), .ADDR_W(32), .RD_LAT(1)) dutA (
        .clk(clk), .reset(reset), .flush(flush), .req_valid(reqValid), .req_ready(readyA),
        .req_we(reqWe), .req_size(reqSize), .req_unsigned(reqUns), .req_addr(reqAddr),
        .req_wdata(reqWdata[31:0]), .data_sram_en(enA), .data_sram_wen(wenA),
        .data_sram_addr(addrA), .data_sram_wdata(wdataA), .data_sram_rdata(rdataA),
        .resp_valid(rvA), .resp_rdata(respA), .resp_exc(excA), .resp_exc_code(codeA),
        .resp_badvaddr(badA));

    lsu_mem_ctrl #(.DATA_W(32), .ADDR_W(32), .RD_LAT(3)) dutB (
        .clk(clk), .reset(reset), .flush(flush), .req_valid(reqValid), .req_ready(readyB),
        .req_we(reqWe), .req_size(reqSize), .req_unsigned(reqUns), .req_addr(reqAddr),
        .req_wdata(reqWdata[31:0]), .data_sram_en(enB), .data_sram_wen(wenB),
        .data_sram_addr(addrB), .data_sram_wdata(wdataB), .data_sram_rdata(rdataB),
        .resp_valid(rvB), .resp_rdata(respB), .resp_exc(excB), .resp_exc_code(codeB),
        .resp_badvaddr(badB));

    lsu_mem_ctrl #(.DATA_W(64), .ADDR_W(32), .RD_LAT(1)) dutC (
        .clk(clk), .reset(reset), .flush(flush), .req_valid(reqValid), .req_ready(readyC),
        .req_we(reqWe), .req_size(reqSize), .req_unsigned(reqUns), .req_addr(reqAddr),
        .req_wdata(reqWdata), .data_sram_en(enC), .data_sram_wen(wenC),
        .data_sram_addr(addrC), .data_sram_wdata(wdataC), .data_sram_rdata(rdataC),
        .resp_valid(rvC), .resp_rdata(respC), .resp_exc(excC), .resp_exc_code(codeC),
        .resp_badvaddr(badC));

    // Output view of the instance a table vector targets (0 = A, 1 = C).
    logic        sel = 1'b0;
    logic        sReady, sEn, sRv, sExc;
    logic [7:0]  sWen;
    logic [31:0] sAddr, sBad;
    logic [63:0] sWdata, sResp;
    logic [4:0]  sCode;

    always_comb begin
        if (sel) begin
            sReady = readyC; sEn = enC; sWen = wenC; sAddr = addrC; sWdata = wdataC;
            sRv = rvC; sResp = respC; sExc = excC; sCode = codeC; sBad = badC;
        end else begin
            sReady = readyA; sEn = enA; sWen = {4'h0, wenA}; sAddr = addrA;
            sWdata = {32'h0, wdataA}; sRv = rvA; sResp = {32'h0, respA};
            sExc = excA; sCode = codeA; sBad = badA;
        end
    end

    typedef struct {
        logic        dut;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic        expEn;
        logic [7:0]  expWen;
        logic [31:0] expAddr;
        logic [63:0] expWdata;
        logic        expExc;
        logic [4:0]  expCode;
        logic [63:0] expRdata;
    } vec_t;

    localparam int unsigned NVEC = 21;
    vec_t tbl [NVEC];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One table transaction on A or C: accept-cycle SRAM signals, then the response.
    task automatic runVec(input int idx);
        vec_t v;
        logic isLoad;
        v = tbl[idx];
        sel = v.dut;
        isLoad = v.expEn && !v.we;
        @(negedge clk);
        reqValid = 1'b1; reqWe = v.we; reqSize = v.size; reqUns = v.uns;
        reqAddr = v.addr; reqWdata = v.wdata;
        rdataA = 32'h5A5A_5A5A; rdataC = 64'h5A5A_5A5A_5A5A_5A5A;
        #1;
        chk($sformatf("v%0d_ready", idx), 64'(sReady), 64'(1'b1));
        chk($sformatf("v%0d_en", idx), 64'(sEn), 64'(v.expEn));
        chk($sformatf("v%0d_wen", idx), 64'(sWen), 64'(v.expWen));
        chk($sformatf("v%0d_addr", idx), 64'(sAddr), 64'(v.expAddr));
        chk($sformatf("v%0d_wdata", idx), sWdata, v.expWdata);
        @(posedge clk);
        @(negedge clk);
        reqValid = 1'b0;
        rdataA = v.rdata[31:0]; rdataC = v.rdata;
        #1;
        chk($sformatf("v%0d_en_idle", idx), 64'(sEn), 64'(1'b0));
        if (isLoad) begin
            chk($sformatf("v%0d_rv_early", idx), 64'(sRv), 64'(1'b0));
            @(negedge clk);
            rdataA = 32'hA5A5_A5A5; rdataC = 64'hA5A5_A5A5_A5A5_A5A5;
            #1;
        end
        chk($sformatf("v%0d_rv", idx), 64'(sRv), 64'(1'b1));
        chk($sformatf("v%0d_rdata", idx), sResp, v.expRdata);
        chk($sformatf("v%0d_exc", idx), 64'(sExc), 64'(v.expExc));
        chk($sformatf("v%0d_code", idx), 64'(sCode), 64'(v.expCode));
        chk($sformatf("v%0d_bad", idx), 64'(sBad), v.expExc ? 64'(v.addr) : 64'h0);
    endtask

    // Single load on B (RD_LAT=3): data presented 3 cycles after en, response at accept+4.
    task automatic loadB(input logic [31:0] addr, input logic [31:0] data, input string name);
        @(negedge clk);
        reqValid = 1'b1; reqWe = 1'b0; reqSize = SZ_W; reqUns = 1'b0; reqAddr = addr;
        #1;
        chk({name, "_en"}, 64'(enB), 64'(1'b1));
        @(posedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            reqValid = 1'b0;
            rdataB = (k == 3) ? data : 32'h2222_2222;
            #1;
            chk($sformatf("%s_rv_k%0d", name, k), 64'(rvB), 64'(k == 4));
            if (k == 4) chk({name, "_rdata"}, 64'(respB), 64'(data));
        end
    endtask

    initial begin
        //             dut   we    size  uns   addr          wdata                  rdata                  en    wen    saddr         swdata                 exc   code   rdata
        tbl[0]  = '{1'b0, 1'b0, SZ_B, 1'b0, 32'h0000_1003, 64'h0,                64'h80FF_1234,         1'b1, 8'h00, 32'h0000_1000, 64'h0,                1'b0, 5'h00, 64'hFFFF_FF80};
        tbl[1]  = '{1'b0, 1'b0, SZ_B, 1'b1, 32'h0000_1003, 64'h0,                64'h80FF_1234,         1'b1, 8'h00, 32'h0000_1000, 64'h0,                1'b0, 5'h00, 64'h0000_0080};
        tbl[2]  = '{1'b0, 1'b1, SZ_H, 1'b0, 32'h0000_2002, 64'h0000_BEEF,        64'h0,                 1'b1, 8'h0C, 32'h0000_2000, 64'hBEEF_0000,        1'b0, 5'h00, 64'h0};
        tbl[3]  = '{1'b0, 1'b0, SZ_W, 1'b0, 32'h0000_3001, 64'h0,                64'h1111_1111,         1'b0, 8'h00, 32'h0,         64'h0,                1'b1, 5'h04, 64'h0};
        tbl[4]  = '{1'b0, 1'b1, SZ_H, 1'b0, 32'h0000_3001, 64'h0000_1234,        64'h0,                 1'b0, 8'h00, 32'h0,         64'h0,                1'b1, 5'h05, 64'h0};
        tbl[5]  = '{1'b0, 1'b0, SZ_H, 1'b0, 32'h0000_1002, 64'h0,                64'h80FF_1234,         1'b1, 8'h00, 32'h0000_1000, 64'h0,                1'b0, 5'h00, 64'hFFFF_80FF};
        tbl[6]  = '{1'b0, 1'b0, SZ_H, 1'b1, 32'h0000_1000, 64'h0,                64'h80FF_9234,         1'b1, 8'h00, 32'h0000_1000, 64'h0,                1'b0, 5'h00, 64'h0000_9234};
        tbl[7]  = '{1'b0, 1'b0, SZ_W, 1'b0, 32'h0000_1004, 64'h0,                64'hDEAD_BEEF,         1'b1, 8'h00, 32'h0000_1004, 64'h0,                1'b0, 5'h00, 64'hDEAD_BEEF};
        tbl[8]  = '{1'b0, 1'b1, SZ_B, 1'b0, 32'h0000_2001, 64'h1234_56A5,        64'h0,                 1'b1, 8'h02, 32'h0000_2000, 64'h3456_A500,        1'b0, 5'h00, 64'h0};
        tbl[9]  = '{1'b0, 1'b1, SZ_W, 1'b0, 32'h0000_2000, 64'hCAFE_F00D,        64'h0,                 1'b1, 8'h0F, 32'h0000_2000, 64'hCAFE_F00D,        1'b0, 5'h00, 64'h0};
        tbl[10] = '{1'b0, 1'b0, SZ_D, 1'b0, 32'h0000_5000, 64'h0,                64'h0,                 1'b0, 8'h00, 32'h0,         64'h0,                1'b1, 5'h04, 64'h0};
        tbl[11] = '{1'b0, 1'b0, SZ_B, 1'b0, 32'h0000_1000, 64'h0,                64'hFFFF_FF7F,         1'b1, 8'h00, 32'h0000_1000, 64'h0,                1'b0, 5'h00, 64'h0000_007F};
        tbl[12] = '{1'b0, 1'b1, SZ_W, 1'b0, 32'h0000_2002, 64'h0,                64'h0,                 1'b0, 8'h00, 32'h0,         64'h0,                1'b1, 5'h05, 64'h0};
        tbl[13] = '{1'b1, 1'b0, SZ_D, 1'b0, 32'h0000_5008, 64'h0,                64'h0123_4567_89AB_CDEF, 1'b1, 8'h00, 32'h0000_5008, 64'h0,              1'b0, 5'h00, 64'h0123_4567_89AB_CDEF};
        tbl[14] = '{1'b1, 1'b0, SZ_D, 1'b0, 32'h0000_5004, 64'h0,                64'h0,                 1'b0, 8'h00, 32'h0,         64'h0,                1'b1, 5'h04, 64'h0};
        tbl[15] = '{1'b1, 1'b1, SZ_B, 1'b0, 32'h0000_5007, 64'h0000_00AB,        64'h0,                 1'b1, 8'h80, 32'h0000_5000, 64'hAB00_0000_0000_0000, 1'b0, 5'h00, 64'h0};
        tbl[16] = '{1'b1, 1'b0, SZ_W, 1'b1, 32'h0000_5004, 64'h0,                64'hFFFF_FFFF_8000_0000, 1'b1, 8'h00, 32'h0000_5000, 64'h0,              1'b0, 5'h00, 64'h0000_0000_FFFF_FFFF};
        tbl[17] = '{1'b1, 1'b0, SZ_W, 1'b0, 32'h0000_5004, 64'h0,                64'hFFFF_FFFF_8000_0000, 1'b1, 8'h00, 32'h0000_5000, 64'h0,              1'b0, 5'h00, 64'hFFFF_FFFF_FFFF_FFFF};
        tbl[18] = '{1'b1, 1'b0, SZ_W, 1'b0, 32'h0000_5000, 64'h0,                64'hFFFF_FFFF_8000_0000, 1'b1, 8'h00, 32'h0000_5000, 64'h0,              1'b0, 5'h00, 64'hFFFF_FFFF_8000_0000};
        tbl[19] = '{1'b1, 1'b1, SZ_D, 1'b0, 32'h0000_5010, 64'h1122_3344_5566_7788, 64'h0,              1'b1, 8'hFF, 32'h0000_5010, 64'h1122_3344_5566_7788, 1'b0, 5'h00, 64'h0};
        tbl[20] = '{1'b1, 1'b1, SZ_H, 1'b0, 32'h0000_5006, 64'h0000_BEEF,        64'h0,                 1'b1, 8'hC0, 32'h0000_5000, 64'hBEEF_0000_0000_0000, 1'b0, 5'h00, 64'h0};

        // Reset state, then ready rises as soon as reset drops.
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        sel = 1'b0;
        chk("rst_ready", 64'(sReady), 64'h0);
        chk("rst_en", 64'(sEn), 64'h0);
        chk("rst_wen", 64'(sWen), 64'h0);
        chk("rst_rv", 64'(sRv), 64'h0);
        chk("rst_exc", 64'(sExc), 64'h0);
        chk("rst_readyB", 64'(readyB), 64'h0);
        reset = 1'b0;
        #1;
        chk("rst_ready_after", 64'(readyA), 64'h1);

        for (int i = 0; i < int'(NVEC); i++) runVec(i);

        // B: load at RD_LAT=3 with a second load waiting behind it.
        repeat (6) @(negedge clk);
        reqValid = 1'b1; reqWe = 1'b0; reqSize = SZ_W; reqUns = 1'b0; reqAddr = 32'h0000_4000;
        rdataB = 32'h1111_1111;
        #1;
        chk("b2b_en0", 64'(enB), 64'h1);
        chk("b2b_addr0", 64'(addrB), 64'h4000);
        @(posedge clk);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 1) reqAddr = 32'h0000_4008;
            if (k == 6) reqValid = 1'b0;
            rdataB = (k == 3) ? 32'hDEAD_BEEF : ((k == 8) ? 32'h0BAD_F00D : 32'h1111_1111);
            #1;
            chk($sformatf("b2b_ready_k%0d", k), 64'(readyB), 64'(k == 5));
            chk($sformatf("b2b_en_k%0d", k), 64'(enB), 64'(k == 5));
            chk($sformatf("b2b_rv_k%0d", k), 64'(rvB), 64'((k == 4) || (k == 9)));
            if (k == 4) chk("b2b_rdata0", 64'(respB), 64'hDEAD_BEEF);
            if (k == 5) chk("b2b_addr1", 64'(addrB), 64'h4008);
            if (k == 9) chk("b2b_rdata1", 64'(respB), 64'h0BAD_F00D);
        end

        // B: flush while waiting on read data drops the response.
        repeat (3) @(negedge clk);
        reqValid = 1'b1; reqWe = 1'b0; reqSize = SZ_W; reqAddr = 32'h0000_4010;
        @(posedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) begin reqValid = 1'b0; flush = 1'b1; end
            if (k == 2) flush = 1'b0;
            rdataB = 32'h5555_5555;
            #1;
            chk($sformatf("flw_rv_k%0d", k), 64'(rvB), 64'h0);
            if (k == 2) chk("flw_ready", 64'(readyB), 64'h1);
        end
        loadB(32'h0000_4020, 32'h1357_9BDF, "flw_after");

        // A: flush during the response cycle suppresses it.
        repeat (3) @(negedge clk);
        reqValid = 1'b1; reqWe = 1'b0; reqSize = SZ_W; reqAddr = 32'h0000_1004;
        @(posedge clk);
        @(negedge clk);
        reqValid = 1'b0; rdataA = 32'h600D_F00D;
        #1;
        chk("flr_rv_k1", 64'(rvA), 64'h0);
        @(negedge clk);
        flush = 1'b1;
        #1;
        chk("flr_rv_k2", 64'(rvA), 64'h0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flr_rv_k3", 64'(rvA), 64'h0);
        chk("flr_ready_k3", 64'(readyA), 64'h1);

        // B: reset while waiting on read data clears everything.
        repeat (6) @(negedge clk);
        reqValid = 1'b1; reqWe = 1'b0; reqSize = SZ_W; reqAddr = 32'h0000_4030;
        @(posedge clk);
        @(negedge clk);
        reqValid = 1'b0; reset = 1'b1;
        @(negedge clk);
        #1;
        chk("rrw_ready", 64'(readyB), 64'h0);
        chk("rrw_en", 64'(enB), 64'h0);
        chk("rrw_wen", 64'(wenB), 64'h0);
        chk("rrw_addr", 64'(addrB), 64'h0);
        chk("rrw_wdata", 64'(wdataB), 64'h0);
        chk("rrw_rv", 64'(rvB), 64'h0);
        chk("rrw_rdata", 64'(respB), 64'h0);
        chk("rrw_exc", 64'(excB), 64'h0);
        chk("rrw_code", 64'(codeB), 64'h0);
        chk("rrw_bad", 64'(badB), 64'h0);
        reset = 1'b0;
        #1;
        chk("rrw_ready_after", 64'(readyB), 64'h1);
        for (int k = 3; k <= 6; k++) begin
            @(negedge clk);
            rdataB = 32'h7777_7777;
            #1;
            chk($sformatf("rrw_rv_k%0d", k), 64'(rvB), 64'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
